// File: rtl/xor_sequencer_pkg.sv
// Shared encodings for the XOR endpoint-register sequencer: datapath
// instructions and sequencer FSM states.
package xor_sequencer_pkg;

    localparam int ISSUED_W = 16;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_SHIFT = 2'b10,
        OP_XOR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/xor_sequencer_down_counter.sv
// Loadable down-counter shared by the repeat and drain phases; zero marks
// the final cycle of the phase currently being timed.
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/xor_sequencer.sv
// Command sequencer driving instruction/serial-in to the endpoint-register
// datapath: each command repeats its op for count+1 cycles, then drains.
module xor_sequencer
    import xor_sequencer_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_zin,
    input  logic             abort,
    output logic [1:0]       inst,
    output logic             ztonxor,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [15:0]      issued_cnt
);

    // Counter must hold both a full repeat count and the drain reload value.
    localparam int DRAIN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int CW       = (CNT_W > DRAIN_W) ? CNT_W : DRAIN_W;
    localparam int DRAIN_LD = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    state_e              state_q, state_d;
    op_e                 inst_q, inst_d;
    logic                ztonxor_q, ztonxor_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [ISSUED_W-1:0] issued_q, issued_d;

    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_load_val;
    logic          accept;

    seq_down_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign cmd_ready = !reset && !abort &&
                       ((state_q == ST_IDLE) || (state_q == ST_ISSUE && cnt_zero));
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        inst_d       = OP_HOLD;
        ztonxor_d    = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        issued_d     = issued_q + ISSUED_W'(inst_q != OP_HOLD);
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = CW'(cmd_count);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_ISSUE;
                    inst_d    = op_e'(cmd_op);
                    ztonxor_d = cmd_zin;
                    cnt_load  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (!cnt_zero) begin
                    inst_d    = inst_q;
                    ztonxor_d = ztonxor_q;
                    cnt_dec   = 1'b1;
                end else if (accept) begin
                    // Back-to-back command: no bubble, no drain, no done.
                    inst_d    = op_e'(cmd_op);
                    ztonxor_d = cmd_zin;
                    cnt_load  = 1'b1;
                end else if (DRAIN_CYC == 0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d      = ST_DRAIN;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(DRAIN_LD);
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            inst_q    <= OP_HOLD;
            ztonxor_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            issued_q  <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            ztonxor_q <= ztonxor_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            issued_q  <= issued_d;
        end
    end

    assign inst       = inst_q;
    assign ztonxor    = ztonxor_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_xor_sequencer.sv
// Directed bench for xor_sequencer: default instance (CNT_W=8, DRAIN_CYC=2)
// plus a CNT_W=4, DRAIN_CYC=0 instance for full-count and no-drain cases.
module tb_xor_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_valid, a_ready, a_zin, a_abort;
    logic [1:0]  a_op, a_inst;
    logic [7:0]  a_count;
    logic        a_z, a_busy, a_done, a_aborted;
    logic [15:0] a_issued;

    logic        b_valid, b_ready, b_zin, b_abort;
    logic [1:0]  b_op, b_inst;
    logic [3:0]  b_count;
    logic        b_z, b_busy, b_done, b_aborted;
    logic [15:0] b_issued;

    int n_cmp = 0;
    int n_bad = 0;

    xor_sequencer #(.CNT_W(8), .DRAIN_CYC(2)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op(a_op), .cmd_count(a_count), .cmd_zin(a_zin), .abort(a_abort),
        .inst(a_inst), .ztonxor(a_z), .busy(a_busy), .done(a_done),
        .aborted(a_aborted), .issued_cnt(a_issued)
    );

    xor_sequencer #(.CNT_W(4), .DRAIN_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_count(b_count), .cmd_zin(b_zin), .abort(b_abort),
        .inst(b_inst), .ztonxor(b_z), .busy(b_busy), .done(b_done),
        .aborted(b_aborted), .issued_cnt(b_issued)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input string tag, input logic [1:0] inst, input logic z,
                       input logic busy, input logic done);
        chk({tag, ".inst"}, 32'(a_inst), 32'(inst));
        chk({tag, ".z"}, 32'(a_z), 32'(z));
        chk({tag, ".busy"}, 32'(a_busy), 32'(busy));
        chk({tag, ".done"}, 32'(a_done), 32'(done));
        chk({tag, ".aborted"}, 32'(a_aborted), 32'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int guard;
        int extra;

        reset = 1'b1;
        a_valid = 1'b0; a_op = 2'b00; a_count = 8'd0; a_zin = 1'b0; a_abort = 1'b0;
        b_valid = 1'b0; b_op = 2'b00; b_count = 4'd0; b_zin = 1'b0; b_abort = 1'b0;
        tick();
        tick();

        // Reset state
        cyc("rst", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst.ready", 32'(a_ready), 32'b0);
        chk("rst.issued", 32'(a_issued), 32'd0);
        chk("rst.b_busy", 32'(b_busy), 32'b0);
        reset = 1'b0;
        #1;
        chk("rst.ready_after", 32'(a_ready), 32'b1);

        // SHIFT count=3 zin=1
        a_valid = 1'b1; a_op = 2'b10; a_count = 8'd3; a_zin = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("t1.issue", 2'b10, 1'b1, 1'b1, 1'b0);
            tick();
        end
        cyc("t1.drain1", 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t1.drain2", 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t1.done", 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t1.issued", 32'(a_issued), 32'd4);
        tick();
        chk("t1.done_once", 32'(a_done), 32'b0);

        // CLEAR count=1 followed back-to-back by XOR count=0
        base = int'(a_issued);
        a_valid = 1'b1; a_op = 2'b01; a_count = 8'd1; a_zin = 1'b0;
        tick();
        a_op = 2'b11; a_count = 8'd0; a_zin = 1'b1;
        #1;
        chk("t2.ready_mid", 32'(a_ready), 32'b0);
        cyc("t2.c1", 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        chk("t2.ready_last", 32'(a_ready), 32'b1);
        cyc("t2.c2", 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        a_valid = 1'b0;
        cyc("t2.c3", 2'b11, 1'b1, 1'b1, 1'b0);
        tick();
        cyc("t2.drain1", 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t2.drain2", 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t2.done", 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t2.issued", 32'(a_issued), 32'(base + 3));
        tick();

        // SHIFT count=10, abort in the 3rd issue cycle
        base = int'(a_issued);
        a_valid = 1'b1; a_op = 2'b10; a_count = 8'd10; a_zin = 1'b0;
        tick();
        a_valid = 1'b0;
        cyc("t3.c1", 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t3.c2", 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t3.c3", 2'b10, 1'b0, 1'b1, 1'b0);
        a_abort = 1'b1;
        #1;
        chk("t3.ready_abort", 32'(a_ready), 32'b0);
        tick();
        a_abort = 1'b0;
        chk("t3.inst", 32'(a_inst), 32'd0);
        chk("t3.aborted", 32'(a_aborted), 32'b1);
        chk("t3.done", 32'(a_done), 32'b0);
        chk("t3.busy", 32'(a_busy), 32'b0);
        chk("t3.issued", 32'(a_issued), 32'(base + 3));
        tick();
        chk("t3.aborted_pulse", 32'(a_aborted), 32'b0);
        chk("t3.no_done", 32'(a_done), 32'b0);

        // abort in IDLE blocks acceptance without an aborted pulse
        a_abort = 1'b1; a_valid = 1'b1; a_op = 2'b10; a_count = 8'd0;
        #1;
        chk("t3i.ready", 32'(a_ready), 32'b0);
        tick();
        a_abort = 1'b0; a_valid = 1'b0;
        chk("t3i.busy", 32'(a_busy), 32'b0);
        chk("t3i.aborted", 32'(a_aborted), 32'b0);

        // HOLD count=2: timed wait
        base = int'(a_issued);
        a_valid = 1'b1; a_op = 2'b00; a_count = 8'd2; a_zin = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("t4.hold", 2'b00, 1'b1, 1'b1, 1'b0);
            tick();
        end
        cyc("t4.drain1", 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t4.drain2", 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        cyc("t4.done", 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t4.issued", 32'(a_issued), 32'(base));
        tick();

        // Reset mid-ISSUE
        a_valid = 1'b1; a_op = 2'b11; a_count = 8'd5; a_zin = 1'b1;
        tick();
        a_valid = 1'b0;
        cyc("t5.c1", 2'b11, 1'b1, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        cyc("t5.rst", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("t5.ready", 32'(a_ready), 32'b0);
        chk("t5.issued", 32'(a_issued), 32'd0);
        reset = 1'b0;
        #1;
        chk("t5.ready_after", 32'(a_ready), 32'b1);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            extra += int'(a_done) + int'(a_aborted);
        end
        chk("t5.no_pulses", 32'(extra), 32'd0);

        // CNT_W=4 full count, DRAIN_CYC=0
        b_valid = 1'b1; b_op = 2'b11; b_count = 4'd15; b_zin = 1'b1;
        tick();
        b_valid = 1'b0;
        n = 0;
        guard = 0;
        while (b_busy && guard < 40) begin
            if (b_inst == 2'b11 && b_z) n++;
            tick();
            guard++;
        end
        chk("t6.bound", 32'(guard < 40), 32'b1);
        chk("t6.issue_cycles", 32'(n), 32'd16);
        chk("t6.done", 32'(b_done), 32'b1);
        chk("t6.issued", 32'(b_issued), 32'd16);
        tick();
        chk("t6.done_once", 32'(b_done), 32'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xor_sequencer.md
XOR_SEQUENCER -- requirements
Module: xor_sequencer

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the per-command repeat count.
REQ-002 The module SHALL have parameter DRAIN_CYC, default 2, giving the number of idle cycles after a command's last issue before done.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port cmd_valid  input  1  command offered.
REQ-006 Port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-007 Port cmd_op  input  2  datapath instruction: 00 HOLD, 01 CLEAR, 10 SHIFT, 11 XOR.
REQ-008 Port cmd_count  input  CNT_W  repeat count; the command issues cmd_count+1 cycles.
REQ-009 Port cmd_zin  input  1  serial-in value driven to the datapath for the whole command.
REQ-010 Port abort  input  1  terminate the current command.
REQ-011 Port inst  output  2  instruction to the endpoint-register datapath.
REQ-012 Port ztonxor  output  1  serial-in bit to the datapath.
REQ-013 Port busy  output  1  high in ISSUE or DRAIN.
REQ-014 Port done  output  1  one-cycle pulse on normal completion.
REQ-015 Port aborted  output  1  one-cycle pulse on abort completion.
REQ-016 Port issued_cnt  output  16  count of non-HOLD instruction cycles issued, wrapping modulo 2^16.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE and DRAIN.
REQ-018 cmd_ready SHALL be high in IDLE, and in ISSUE on the last issue cycle (remaining count = 0); it SHALL be low otherwise, and low whenever abort or reset is high.
REQ-019 On acceptance at edge k, inst SHALL equal cmd_op and ztonxor SHALL equal cmd_zin from cycle k+1 for exactly cmd_count+1 cycles, registered with no combinational input-to-output path.
REQ-020 Outside ISSUE, inst SHALL be 2'b00 and ztonxor SHALL be 0.
REQ-021 In the last ISSUE cycle, if a command is accepted, the FSM SHALL stay in ISSUE, the new command SHALL start with no bubble, DRAIN SHALL be skipped, and no done SHALL be emitted for the earlier command.
REQ-022 In the last ISSUE cycle with no acceptance, the FSM SHALL go to DRAIN for DRAIN_CYC cycles, then to IDLE, with done pulsing in the first IDLE cycle.
REQ-023 DRAIN_CYC = 0 SHALL go directly from ISSUE to IDLE, with done pulsing in that IDLE cycle.
REQ-024 A cmd_count of all-ones SHALL issue 2^CNT_W cycles; the count SHALL NOT wrap early.
REQ-025 HOLD (op 00) commands SHALL be legal: they sequence a timed wait and do not increment issued_cnt.
REQ-026 abort high in ISSUE or DRAIN SHALL move the FSM to IDLE at the next edge, force inst = 00 from that cycle, suppress done, and pulse aborted for one cycle.
REQ-027 abort high in IDLE SHALL block acceptance and SHALL NOT pulse aborted.
REQ-028 issued_cnt SHALL increment once per cycle in which inst is not 00.

Reset
REQ-029 While reset is high, the FSM SHALL be in IDLE, and inst = 00, ztonxor = 0, cmd_ready = 0, busy = 0, done = 0, aborted = 0 and issued_cnt = 0.
REQ-030 Reset asserted mid-command SHALL discard the command without emitting done or aborted.
REQ-031 In the first cycle after reset deasserts, cmd_ready SHALL be 1.

Structure
REQ-032 A shared package SHALL hold the instruction encodings (HOLD, CLEAR, SHIFT, XOR) and the FSM state enumeration.
REQ-033 The repeat/drain down-counter SHALL be a single sub-module named seq_down_counter (load, decrement, zero flag).

Verification
REQ-034 Reset pulse, then SHIFT count=3 zin=1 -> inst=10 and ztonxor=1 for 4 cycles, 2 DRAIN cycles, done once, issued_cnt=4.
REQ-035 XOR count=0 accepted on the last cycle of CLEAR count=1 -> inst sequence 01,01,11 with no gap, a single done, issued_cnt=3.
REQ-036 SHIFT count=10, abort in the 3rd issue cycle -> inst=00 from the next cycle, aborted pulses, no done, issued_cnt=3.
REQ-037 HOLD count=2 -> inst=00 with busy=1 for 3 cycles, then done, issued_cnt unchanged.
REQ-038 CNT_W=4, count=15 -> exactly 16 issue cycles.
REQ-039 Reset asserted mid-ISSUE -> all outputs reach their reset values by the next cycle, no done or aborted.
